can_data_field_rx: RTL and testbench



---
 rtl/can_fd_pkg.sv | 10 +
 rtl/can_bit_shifter.sv | 29 ++
 rtl/can_data_field_rx.sv | 96 +++++++++
 tb/tb_can_data_field_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_fd_pkg.sv
// Shared types and constants for the CAN FD receive data-field path.
package can_fd_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_data_state_t;

  localparam int CAN_FD_MAX_BYTES = 64;
  localparam int CAN_FD_LEN_W     = 7;
endpackage

// File: rtl/can_bit_shifter.sv
// MSB-first byte deserialiser: 8-bit shift register plus a 3-bit bit counter.
module can_bit_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_shift_en,
  input  logic       i_bit,
  output logic [7:0] o_byte,
  output logic       o_byte_ready
);
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;

  // The completed byte includes the bit being accepted this cycle.
  assign o_byte       = {r_shift[6:0], i_bit};
  assign o_byte_ready = i_shift_en && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
    end else if (i_clear) begin
      r_bit_cnt <= 3'd0;
    end else if (i_shift_en) begin
      r_shift   <= {r_shift[6:0], i_bit};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/can_data_field_rx.sv
// CAN FD data-field collector: latches the byte count, deserialises destuffed
// bits into bytes, writes them to the receive buffer and pulses done at the end.
module can_data_field_rx
  import can_fd_pkg::*;
#(
  parameter int MAX_BYTES = CAN_FD_MAX_BYTES,
  parameter int ADDR_W    = 6,
  parameter int LEN_W     = CAN_FD_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start_data,
  input  logic [LEN_W-1:0]  i_data_len,
  input  logic              i_sample_point,
  input  logic              i_sampled_bit,
  input  logic              i_bit_de_stuff,
  input  logic              i_abort,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [LEN_W-1:0]  o_byte_cnt,
  output logic              o_busy,
  output logic              o_done
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  rx_data_state_t    r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len_q, r_byte_cnt, w_sat_len, w_cnt_inc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data, w_byte;
  logic              r_wr_en, r_done;
  logic              w_accept, w_byte_ready, w_last;

  assign w_sat_len = (i_data_len > MAX_LEN) ? MAX_LEN : i_data_len;
  assign w_accept  = i_sample_point && !i_bit_de_stuff && (r_state == RECV)
                     && !i_start_data && !i_abort;
  assign w_cnt_inc = r_byte_cnt + LEN_W'(1);
  assign w_last    = w_byte_ready && (w_cnt_inc == r_len_q);

  can_bit_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_start_data),
    .i_shift_en   (w_accept),
    .i_bit        (i_sampled_bit),
    .o_byte       (w_byte),
    .o_byte_ready (w_byte_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort)           w_state_nxt = IDLE;
    else if (i_start_data) w_state_nxt = (w_sat_len == '0) ? IDLE : RECV;
    else if (w_last)       w_state_nxt = IDLE;
  end

  // Strobes default low so wr_en and done are single-cycle by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q    <= '0;
      r_byte_cnt <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'd0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (!i_abort) begin
        if (i_start_data) begin
          r_len_q    <= w_sat_len;
          r_byte_cnt <= '0;
          r_done     <= (w_sat_len == '0);
        end else if (w_byte_ready) begin
          r_wr_data  <= w_byte;
          r_wr_addr  <= r_byte_cnt[ADDR_W-1:0];
          r_wr_en    <= 1'b1;
          r_byte_cnt <= w_cnt_inc;
          r_done     <= w_last;
        end
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_byte_cnt = r_byte_cnt;
  assign o_busy     = (r_state == RECV);
  assign o_done     = r_done;
endmodule

// File: tb/tb_can_data_field_rx.sv
// Bench for can_data_field_rx: randomized frames against a byte-level model plus timing corner cases.
module tb_can_data_field_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start_data, i_sample_point, i_sampled_bit, i_bit_de_stuff, i_abort;
  logic [6:0] i_data_len;
  logic       o_wr_en, o_busy, o_done;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic [6:0] o_byte_cnt;

  can_data_field_rx dut (
    .clk(clk), .rst_n(rst_n), .i_start_data(i_start_data), .i_data_len(i_data_len),
    .i_sample_point(i_sample_point), .i_sampled_bit(i_sampled_bit),
    .i_bit_de_stuff(i_bit_de_stuff), .i_abort(i_abort), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_byte_cnt(o_byte_cnt),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { int addr; int data; } rec_t;
  rec_t wr_q[$];
  int done_cnt = 0, done_wr_cnt = 0, busy_cycles = 0, dbl_cnt = 0;
  logic prev_wr = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (o_wr_en) wr_q.push_back('{int'(o_wr_addr), int'(o_wr_data)});
    if (o_done) begin
      done_cnt++;
      if (o_wr_en) done_wr_cnt++;
    end
    if (o_busy) busy_cycles++;
    if (o_wr_en && prev_wr) dbl_cnt++;
    if (o_done && prev_done) dbl_cnt++;
    prev_wr   = o_wr_en;
    prev_done = o_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int len);
    i_start_data = 1'b1;
    i_data_len   = 7'(len);
    tick();
    i_start_data = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic stuff);
    i_sample_point = 1'b1;
    i_sampled_bit  = b;
    i_bit_de_stuff = stuff;
    tick();
    i_sample_point = 1'b0;
    i_bit_de_stuff = 1'b0;
  endtask

  task automatic send_byte_tight(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_bit(v[k], 1'b0);
  endtask

  // Random gaps and random stuff strobes around each data bit.
  task automatic send_bits_rand(input logic bits[$]);
    foreach (bits[k]) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 5) == 0) send_bit(1'($urandom_range(0, 1)), 1'b1);
      send_bit(bits[k], 1'b0);
    end
  endtask

  // Reference: bytes stored are the first min(len,64, whole bytes sent) data bytes.
  function automatic int model_count(input int len, input int nbits);
    int sat = (len > 64) ? 64 : len;
    return (nbits / 8 < sat) ? nbits / 8 : sat;
  endfunction

  task automatic check_writes(input string tag, input int base, input logic [7:0] bytes[$], input int n);
    for (int k = 0; k < n; k++) begin
      if (base + k < wr_q.size()) begin
        check({tag, "_addr"}, wr_q[base + k].addr, k);
        check({tag, "_data"}, wr_q[base + k].data, bytes[k]);
      end
    end
  endtask

  typedef struct {
    int len; int nbits; int exp_wr; int exp_done; int exp_cnt; int exp_busy;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [7:0] bytes[$];
    logic       bits[$];
    int wb, db, dwb, bb, n;

    vecs[0] = '{0,   16,  0,  1, 0,  0};
    vecs[1] = '{1,   8,   1,  1, 1,  0};
    vecs[2] = '{2,   16,  2,  1, 2,  0};
    vecs[3] = '{8,   40,  5,  0, 5,  1};
    vecs[4] = '{8,   80,  8,  1, 8,  0};
    vecs[5] = '{100, 520, 64, 1, 64, 0};
    vecs[6] = '{12,  100, 12, 1, 12, 0};
    vecs[7] = '{64,  512, 64, 1, 64, 0};

    rst_n = 1'b0;
    i_start_data = 0; i_data_len = 0; i_sample_point = 0;
    i_sampled_bit = 0; i_bit_de_stuff = 0; i_abort = 0;
    #8;
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_byte_cnt", o_byte_cnt, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    #4 rst_n = 1'b1;
    tick();

    // Two bytes back to back with exact write/done timing.
    wb = wr_q.size();
    start_pulse(2);
    send_byte_tight(8'hA5);
    @(negedge clk);
    check("t2_wr0_en", o_wr_en, 1);
    check("t2_wr0_addr", o_wr_addr, 0);
    check("t2_wr0_data", o_wr_data, 8'hA5);
    check("t2_wr0_done", o_done, 0);
    #1;
    send_byte_tight(8'h3C);
    @(negedge clk);
    check("t2_wr1_en", o_wr_en, 1);
    check("t2_wr1_addr", o_wr_addr, 1);
    check("t2_wr1_data", o_wr_data, 8'h3C);
    check("t2_done", o_done, 1);
    check("t2_byte_cnt", o_byte_cnt, 2);
    @(negedge clk);
    check("t2_busy_after", o_busy, 0);
    check("t2_done_one_cycle", o_done, 0);
    check("t2_wr_one_cycle", o_wr_en, 0);
    #1;

    // Zero length: done one cycle after start, no writes, never busy.
    wb = wr_q.size(); bb = busy_cycles;
    start_pulse(0);
    @(negedge clk);
    check("z_done", o_done, 1);
    @(negedge clk);
    check("z_done_drop", o_done, 0);
    #1;
    send_byte_tight(8'hFF);
    tick(); tick();
    check("z_writes", wr_q.size() - wb, 0);
    check("z_busy_seen", busy_cycles - bb, 0);

    // Stuff bit inside the byte is skipped.
    wb = wr_q.size();
    start_pulse(1);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 1); send_bit(1, 0); send_bit(0, 0);
    send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    tick(); tick();
    check("stuff_writes", wr_q.size() - wb, 1);
    if (wr_q.size() > wb) check("stuff_data", wr_q[wb].data, 8'hA5);

    // Table of randomized frames against the byte-level model.
    for (int v = 0; v < 8; v++) begin
      bytes.delete(); bits.delete();
      for (int k = 0; k < (vecs[v].nbits + 7) / 8; k++) bytes.push_back(8'($urandom));
      for (int k = 0; k < vecs[v].nbits; k++) bits.push_back(bytes[k / 8][7 - (k % 8)]);
      wb = wr_q.size(); db = done_cnt; dwb = done_wr_cnt;
      start_pulse(vecs[v].len);
      send_bits_rand(bits);
      tick(); tick(); tick();
      n = model_count(vecs[v].len, vecs[v].nbits);
      check($sformatf("v%0d_writes", v), wr_q.size() - wb, vecs[v].exp_wr);
      check($sformatf("v%0d_model_writes", v), wr_q.size() - wb, n);
      check_writes($sformatf("v%0d", v), wb, bytes, n);
      check($sformatf("v%0d_done", v), done_cnt - db, vecs[v].exp_done);
      check($sformatf("v%0d_done_with_wr", v), done_wr_cnt - dwb,
            (vecs[v].len != 0) ? vecs[v].exp_done : 0);
      check($sformatf("v%0d_byte_cnt", v), o_byte_cnt, vecs[v].exp_cnt);
      check($sformatf("v%0d_busy", v), o_busy, vecs[v].exp_busy);
    end

    // Abort after 5 bytes + 3 bits, then a fresh one-byte frame.
    bytes.delete(); bits.delete();
    for (int k = 0; k < 6; k++) bytes.push_back(8'($urandom));
    for (int k = 0; k < 43; k++) bits.push_back(bytes[k / 8][7 - (k % 8)]);
    wb = wr_q.size(); db = done_cnt;
    start_pulse(12);
    send_bits_rand(bits);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tick(); tick();
    check("ab_writes", wr_q.size() - wb, 5);
    check_writes("ab", wb, bytes, 5);
    check("ab_done", done_cnt - db, 0);
    check("ab_busy", o_busy, 0);
    check("ab_byte_cnt", o_byte_cnt, 5);
    send_byte_tight(8'hFF);
    tick();
    check("ab_idle_writes", wr_q.size() - wb, 5);
    wb = wr_q.size(); db = done_cnt;
    start_pulse(1);
    send_byte_tight(8'h5A);
    tick(); tick();
    check("ab2_writes", wr_q.size() - wb, 1);
    if (wr_q.size() > wb) begin
      check("ab2_addr", wr_q[wb].addr, 0);
      check("ab2_data", wr_q[wb].data, 8'h5A);
    end
    check("ab2_done", done_cnt - db, 1);
    check("ab2_byte_cnt", o_byte_cnt, 1);

    // Asynchronous reset in the middle of a byte.
    start_pulse(4);
    send_byte_tight(8'hC3);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    tick();
    check("ar_pre_cnt", o_byte_cnt, 1);
    check("ar_pre_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wr_en", o_wr_en, 0);
    check("ar_wr_addr", o_wr_addr, 0);
    check("ar_wr_data", o_wr_data, 0);
    check("ar_byte_cnt", o_byte_cnt, 0);
    check("ar_busy", o_busy, 0);
    check("ar_done", o_done, 0);
    #1 rst_n = 1'b1;
    tick();

    check("single_cycle_strobes", dbl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
